// File: rtl/ntt_pkg.sv
// +----------------------------------------------------------------------+
// | ntt_pkg : shared constants and FSM state type for the twiddle path   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package ntt_pkg;

  localparam int N     = 25;
  localparam int TW_W  = 12;
  localparam int Q     = 3329;
  localparam int OMEGA = 2580;
  localparam int NTW   = 4;
  localparam int IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EMIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } tw_state_e;

endpackage

`default_nettype wire

// File: rtl/tw_mult.sv
// +----------------------------------------------------------------------+
// | tw_mult : registered A_W x A_W multiplier, zero-extended to P_W bits |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tw_mult
  import ntt_pkg::*;
#(
  parameter int A_W = TW_W,
  parameter int P_W = N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en_i,
  input  logic [A_W-1:0] a_i,
  input  logic [A_W-1:0] b_i,
  output logic [P_W-1:0] p_o
);

  logic [P_W-1:0] p_q;
  logic [P_W-1:0] p_d;

  // Operands widened first so the product keeps every bit.
  assign p_d = P_W'(a_i) * P_W'(b_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

`default_nettype wire

// File: rtl/tw_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tw_seq_ctrl : twiddle power sequencer W^0..W^(NTW-1) mod Q           |
// | Optional macro TW_RANGE_CHECK_EN adds sticky range_err output.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tw_seq_ctrl
  import ntt_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [N-1:0]     red_inp,
  output logic             red_req,
  input  logic [N-1:0]     red_out,
  input  logic             red_ack,
  output logic [TW_W-1:0]  tw_out,
  output logic [IDX_W-1:0] tw_idx,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic             busy,
  output logic             done
`ifdef TW_RANGE_CHECK_EN
  ,
  output logic             range_err
`endif
);

  tw_state_e        state_q;
  logic [TW_W-1:0]  cur_tw_q;
  logic [IDX_W-1:0] k_q;
  logic [IDX_W-1:0] k_d;
  logic             red_req_q;
  logic             tw_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             w_accept;
  logic             w_last;
  logic             w_mult_en;

  assign w_accept  = (state_q == ST_EMIT) && tw_valid_q && tw_ready;
  assign w_last    = (k_q == IDX_W'(NTW - 1));
  assign k_d       = k_q + 1'b1;
  // Product is registered on the acceptance edge so it is on red_inp in ISSUE.
  assign w_mult_en = w_accept && !w_last;

  tw_mult #(
    .A_W (TW_W),
    .P_W (N)
  ) u_tw_mult (
    .clock (clock),
    .reset (reset),
    .en_i  (w_mult_en),
    .a_i   (cur_tw_q),
    .b_i   (TW_W'(OMEGA)),
    .p_o   (red_inp)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cur_tw_q   <= '0;
      k_q        <= '0;
      red_req_q  <= 1'b0;
      tw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cur_tw_q   <= TW_W'(1);
            k_q        <= '0;
            busy_q     <= 1'b1;
            tw_valid_q <= 1'b1;
            state_q    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_accept) begin
            tw_valid_q <= 1'b0;
            if (w_last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              red_req_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (red_ack) begin
            cur_tw_q   <= red_out[TW_W-1:0];
            k_q        <= k_d;
            red_req_q  <= 1'b0;
            tw_valid_q <= 1'b1;
            state_q    <= ST_EMIT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TW_RANGE_CHECK_EN
  logic range_err_q;
  logic w_range_bad;

  assign w_range_bad = (red_out >= N'(Q)) || red_out[N-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      range_err_q <= 1'b0;
    end else if ((state_q == ST_WAIT) && red_ack && w_range_bad) begin
      range_err_q <= 1'b1;
    end
  end

  assign range_err = range_err_q;
`else
  logic w_unused_red_out_hi;
  assign w_unused_red_out_hi = ^red_out[N-1:TW_W];
`endif

  assign red_req  = red_req_q;
  assign tw_out   = cur_tw_q;
  assign tw_idx   = k_q;
  assign tw_valid = tw_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tw_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_tw_seq_ctrl : scoreboard bench for tw_seq_ctrl with reducer model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_tw_seq_ctrl;

  localparam int TQ     = 3329;
  localparam int TOMEGA = 2580;
  localparam int TNTW   = 4;
  localparam int ACK_DLY = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [24:0] red_inp;
  logic        red_req;
  logic [24:0] red_out;
  logic        red_ack;
  logic [11:0] tw_out;
  logic [1:0]  tw_idx;
  logic        tw_valid;
  logic        tw_ready;
  logic        busy;
  logic        done;
`ifdef TW_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_tw[$];
  int exp_idx[$];
  int exp_inp[$];
  logic stray     = 1'b0;
  logic force_bad = 1'b0;

  tw_seq_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .red_inp  (red_inp),
    .red_req  (red_req),
    .red_out  (red_out),
    .red_ack  (red_ack),
    .tw_out   (tw_out),
    .tw_idx   (tw_idx),
    .tw_valid (tw_valid),
    .tw_ready (tw_ready),
    .busy     (busy),
    .done     (done)
`ifdef TW_RANGE_CHECK_EN
    ,
    .range_err(range_err)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_seq();
    int w = 1;
    for (int k = 0; k < TNTW; k++) begin
      exp_tw.push_back(w);
      exp_idx.push_back(k);
      if (k < TNTW - 1) begin
        exp_inp.push_back(w * TOMEGA);
        w = (w * TOMEGA) % TQ;
      end
    end
  endtask

  task automatic flush_q();
    exp_tw.delete();
    exp_idx.delete();
    exp_inp.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int t = 0;
    while (!(tw_valid === 1'b1 && tw_idx == idx) && t < 200) begin
      tick(1);
      t++;
    end
    chk(tag, (tw_valid === 1'b1 && tw_idx == idx), 1);
  endtask

  task automatic wait_req(input string tag);
    int t = 0;
    while (red_req !== 1'b1 && t < 200) begin
      tick(1);
      t++;
    end
    chk(tag, red_req, 1);
  endtask

  task automatic wait_done(input string tag);
    int target = done_cnt + 1;
    int t = 0;
    while (done_cnt < target && t < 300) begin
      tick(1);
      t++;
    end
    chk(tag, done_cnt, target);
  endtask

  // Reducer model: acks ACK_DLY cycles after red_req rises with red_inp mod Q.
  initial begin
    int cnt = 0;
    logic pending = 1'b0;
    logic req_prev = 1'b0;
    logic ack_chk = 1'b0;
    red_ack = 1'b0;
    red_out = '0;
    forever begin
      @(negedge clock);
      red_ack = 1'b0;
      if (ack_chk) begin
        if (!reset) chk("ack_to_valid", tw_valid, 1);
        ack_chk = 1'b0;
      end
      if (stray) begin
        red_ack = 1'b1;
        red_out = 25'd999;
      end
      if (red_req && !req_prev && !reset) begin
        pending = 1'b1;
        cnt = 0;
        if (exp_inp.size() > 0) chk("red_inp", red_inp, exp_inp.pop_front());
        else chk("red_inp_extra", exp_inp.size(), 1);
      end else if (pending) begin
        cnt++;
        if (cnt == ACK_DLY) begin
          red_ack = 1'b1;
          red_out = force_bad ? 25'd3329 : 25'(int'(red_inp) % TQ);
          pending = 1'b0;
          ack_chk = red_req;
        end
      end
      req_prev = red_req;
    end
  end

  // Output monitor: pops the scoreboard on each accepted twiddle.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done === 1'b1) done_cnt++;
        if (tw_valid === 1'b1 && tw_ready === 1'b1) begin
          if (exp_tw.size() > 0) begin
            chk("tw_out", tw_out, exp_tw.pop_front());
            chk("tw_idx", tw_idx, exp_idx.pop_front());
          end else begin
            chk("tw_extra", exp_tw.size(), 1);
          end
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    tw_ready = 1'b0;
    tick(3);
    chk("rst_red_inp", red_inp, 0);
    chk("rst_red_req", red_req, 0);
    chk("rst_tw_out", tw_out, 0);
    chk("rst_tw_idx", tw_idx, 0);
    chk("rst_tw_valid", tw_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick(1);

    // Stray ack while idle.
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    tick(2);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_valid", tw_valid, 0);

    // Nominal sequence with a start pulse while busy.
    tw_ready = 1'b1;
    push_seq();
    pulse_start();
    chk("start_lat_valid", tw_valid, 1);
    chk("start_lat_busy", busy, 1);
    wait_req("nom_req");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("nom_done");
    tick(2);
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_busy", busy, 0);
    chk("nom_tw_left", exp_tw.size(), 0);
    chk("nom_inp_left", exp_inp.size(), 0);

    // Backpressure at k=1 with a stray ack in EMIT.
    push_seq();
    pulse_start();
    wait_idx(1, "bp_reach_k1");
    tw_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      stray = (i == 3);
      tick(1);
      chk("bp_tw_out", tw_out, TOMEGA);
      chk("bp_tw_idx", tw_idx, 1);
      chk("bp_no_issue", red_req, 0);
    end
    stray = 1'b0;
    tw_ready = 1'b1;
    wait_done("bp_done");
    tick(2);
    chk("bp_done_cnt", done_cnt, 2);
    chk("bp_tw_left", exp_tw.size(), 0);

    // Reset in WAIT at k=2; reducer ack lands after reset is released.
    push_seq();
    pulse_start();
    wait_idx(2, "rw_reach_k2");
    wait_req("rw_req");
    tick(2);
    reset = 1'b1;
    flush_q();
    tick(2);
    reset = 1'b0;
    chk("rw_red_inp", red_inp, 0);
    chk("rw_red_req", red_req, 0);
    chk("rw_tw_valid", tw_valid, 0);
    chk("rw_busy", busy, 0);
    tick(8);
    chk("rw_late_tw_out", tw_out, 0);
    chk("rw_late_valid", tw_valid, 0);
    chk("rw_late_busy", busy, 0);
    push_seq();
    pulse_start();
    chk("rw_restart_tw", tw_out, 1);
    wait_done("rw_done");
    tick(2);
    chk("rw_tw_left", exp_tw.size(), 0);

`ifdef TW_RANGE_CHECK_EN
    chk("rc_init", range_err, 0);
    force_bad = 1'b1;
    exp_tw.push_back(1);
    exp_idx.push_back(0);
    exp_tw.push_back(TQ);
    exp_idx.push_back(1);
    exp_inp.push_back(TOMEGA);
    pulse_start();
    wait_idx(1, "rc_reach_k1");
    tw_ready = 1'b0;
    chk("rc_captured", tw_out, TQ);
    chk("rc_set", range_err, 1);
    tick(4);
    chk("rc_sticky", range_err, 1);
    reset = 1'b1;
    flush_q();
    tick(1);
    chk("rc_cleared", range_err, 0);
    reset = 1'b0;
    force_bad = 1'b0;
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
